// File: rtl/dpa_tap_scan_sequencer_pkg.sv
// Shared types and helpers for the DPA tap-scan sequencer: state encoding,
// default tap width and the eye-centre computation.
package dpa_ctrl_pkg;

   localparam int DPA_TAP_W = 5;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_SETTLE    = 3'd2,
      S_CHECK     = 3'd3,
      S_EVAL      = 3'd4,
      S_APPLY     = 3'd5,
      S_NEXT_LANE = 3'd6
   } dpa_scan_state_t;

   // Lower-middle tap of the eye; caller truncates to the tap width.
   function automatic logic [31:0] dpa_centre(input logic [31:0] start,
                                              input logic [31:0] len);
      return start + ((len - 32'd1) >> 1);
   endfunction

endpackage

// File: rtl/dpa_tap_scan_sequencer_if.sv
// Control/status bundle between the tap-scan sequencer (master) and the
// register block plus lane datapath (slave).
interface dpa_tap_scan_sequencer_if #(
   parameter int N_LANES = 8,
   parameter int TAP_W   = dpa_ctrl_pkg::DPA_TAP_W
);
   localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

   // All strobes (start, abort, done, tap_load, result_valid) are single-cycle
   // pulses with no backpressure; the receiver must act on the cycle they are high.
   logic               start;
   logic               abort;
   logic               pattern_ok;
   logic               busy;
   logic               done;
   logic [LW-1:0]      lane_sel;
   logic               tap_load;
   logic [TAP_W-1:0]   tap_value;
   logic               result_valid;
   logic [TAP_W-1:0]   result_tap;
   logic [TAP_W:0]     result_width;
   logic [N_LANES-1:0] lane_fail;
   logic [2:0]         dbg_state;

   modport master (
      input  start, abort, pattern_ok,
      output busy, done, lane_sel, tap_load, tap_value,
             result_valid, result_tap, result_width, lane_fail, dbg_state
   );

   modport slave (
      output start, abort, pattern_ok,
      input  busy, done, lane_sel, tap_load, tap_value,
             result_valid, result_tap, result_width, lane_fail, dbg_state
   );

endinterface

// File: rtl/dpa_tap_scan_sequencer_eye_tracker.sv
// Tracks the current run of passing taps and the widest run seen so far for
// one lane; cleared between lanes.
module dpa_eye_tracker
   import dpa_ctrl_pkg::*;
#(
   parameter int TAP_W = DPA_TAP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_eval,
   input  logic             i_pass,
   input  logic             i_last,
   input  logic [TAP_W-1:0] i_tap,
   output logic [TAP_W-1:0] o_best_start,
   output logic [TAP_W:0]   o_best_len
);
   localparam int LEN_W = TAP_W + 1;

   logic [TAP_W-1:0] r_cur_start, r_best_start;
   logic [LEN_W-1:0] r_cur_len, r_best_len;

   logic [TAP_W-1:0] w_ext_start, w_cand_start;
   logic [LEN_W-1:0] w_ext_len, w_cand_len;
   logic             w_close;

   assign w_ext_start  = (r_cur_len == '0) ? i_tap : r_cur_start;
   assign w_ext_len    = r_cur_len + LEN_W'(1);
   // A pass on the last tap closes the run including that tap.
   assign w_cand_start = i_pass ? w_ext_start : r_cur_start;
   assign w_cand_len   = i_pass ? w_ext_len : r_cur_len;
   assign w_close      = i_eval & (~i_pass | i_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_start  <= '0;
         r_cur_len    <= '0;
         r_best_start <= '0;
         r_best_len   <= '0;
      end else if (i_clear) begin
         r_cur_start  <= '0;
         r_cur_len    <= '0;
         r_best_start <= '0;
         r_best_len   <= '0;
      end else if (i_eval) begin
         r_cur_start <= i_pass ? w_ext_start : r_cur_start;
         r_cur_len   <= i_pass ? w_ext_len : '0;
         // Strictly longer only, so the earliest of equal runs is kept.
         if (w_close && (w_cand_len > r_best_len)) begin
            r_best_start <= w_cand_start;
            r_best_len   <= w_cand_len;
         end
      end
   end

   assign o_best_start = r_best_start;
   assign o_best_len   = r_best_len;

endmodule

// File: rtl/dpa_tap_scan_sequencer.sv
// Sweeps every delay tap on each lane, qualifies it against the lane pattern
// checker and loads the centre of the widest passing eye.
module dpa_tap_scan_sequencer
   import dpa_ctrl_pkg::*;
#(
   parameter int N_LANES       = 8,
   parameter int TAP_W         = DPA_TAP_W,
   parameter int SETTLE_CYCLES = 16,
   parameter int CHECK_CYCLES  = 256
) (
   input logic                 ACLK,
   input logic                 ARESETN,
   dpa_tap_scan_sequencer_if.master bus
);
   localparam int LW      = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [2:0] ST_IDLE      = S_IDLE;
   localparam logic [2:0] ST_LOAD      = S_LOAD;
   localparam logic [2:0] ST_SETTLE    = S_SETTLE;
   localparam logic [2:0] ST_CHECK     = S_CHECK;
   localparam logic [2:0] ST_EVAL      = S_EVAL;
   localparam logic [2:0] ST_APPLY     = S_APPLY;
   localparam logic [2:0] ST_NEXT_LANE = S_NEXT_LANE;

   localparam logic [TAP_W-1:0] TAP_MAX = {TAP_W{1'b1}};

   logic [2:0]         r_state;
   logic [LW-1:0]      r_lane;
   logic [TAP_W-1:0]   r_tap;
   logic [CW-1:0]      r_cnt;
   logic               r_pass;
   logic [N_LANES-1:0] r_lane_fail;

   logic [TAP_W-1:0]   w_best_start;
   logic [TAP_W:0]     w_best_len;
   logic [TAP_W-1:0]   w_centre;
   logic               w_last_lane, w_last_tap, w_trk_clear, w_apply;

   assign w_last_lane = (r_lane == LW'(N_LANES - 1));
   assign w_last_tap  = (r_tap == TAP_MAX);
   assign w_apply     = (r_state == ST_APPLY);
   assign w_trk_clear = ((r_state == ST_IDLE) & bus.start & ~bus.abort) |
                        ((r_state == ST_NEXT_LANE) & ~w_last_lane);
   assign w_centre    = (w_best_len == '0) ? '0 :
                        TAP_W'(dpa_centre(32'(w_best_start), 32'(w_best_len)));

   dpa_eye_tracker #(.TAP_W(TAP_W)) u_tracker (
      .clk          (ACLK),
      .rst_n        (ARESETN),
      .i_clear      (w_trk_clear),
      .i_eval       (r_state == ST_EVAL),
      .i_pass       (r_pass),
      .i_last       (w_last_tap),
      .i_tap        (r_tap),
      .o_best_start (w_best_start),
      .o_best_len   (w_best_len)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state     <= ST_IDLE;
         r_lane      <= '0;
         r_tap       <= '0;
         r_cnt       <= '0;
         r_pass      <= 1'b0;
         r_lane_fail <= '0;
      end else if ((r_state != ST_IDLE) && bus.abort) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start && !bus.abort) begin
                  r_lane_fail <= '0;
                  r_lane      <= '0;
                  r_tap       <= '0;
                  r_state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_cnt   <= '0;
               r_pass  <= 1'b1;
               r_state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                  r_cnt   <= '0;
                  r_state <= ST_CHECK;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_CHECK: begin
               r_pass <= r_pass & bus.pattern_ok;
               if (r_cnt == CW'(CHECK_CYCLES - 1)) begin
                  r_state <= ST_EVAL;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_EVAL: begin
               if (w_last_tap) begin
                  r_state <= ST_APPLY;
               end else begin
                  r_tap   <= r_tap + TAP_W'(1);
                  r_state <= ST_LOAD;
               end
            end
            ST_APPLY: begin
               if (w_best_len == '0) r_lane_fail[r_lane] <= 1'b1;
               r_state <= ST_NEXT_LANE;
            end
            ST_NEXT_LANE: begin
               if (w_last_lane) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_lane  <= r_lane + LW'(1);
                  r_tap   <= '0;
                  r_state <= ST_LOAD;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy         = (r_state != ST_IDLE);
   assign bus.done         = (r_state == ST_NEXT_LANE) & w_last_lane & ~bus.abort;
   assign bus.lane_sel     = r_lane;
   assign bus.tap_load     = (r_state == ST_LOAD) | w_apply;
   assign bus.tap_value    = w_apply ? w_centre : r_tap;
   assign bus.result_valid = w_apply;
   assign bus.result_tap   = w_apply ? w_centre : '0;
   assign bus.result_width = w_apply ? w_best_len : '0;
   assign bus.lane_fail    = r_lane_fail;
   assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_dpa_tap_scan_sequencer.sv
// Directed bench for dpa_tap_scan_sequencer: per-lane pass masks model the
// pattern checkers; lane results are scoreboarded against hand-computed eyes.
module tb_dpa_tap_scan_sequencer;
   import dpa_ctrl_pkg::*;

   localparam int NL       = 2;
   localparam int TW       = 5;
   localparam int SC       = 4;
   localparam int CC       = 8;
   localparam int SCAN_CYC = NL * ((1 << TW) * (SC + CC + 2) + 2);

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dpa_tap_scan_sequencer_if #(.N_LANES(NL), .TAP_W(TW)) ifc ();

   dpa_tap_scan_sequencer #(
      .N_LANES(NL), .TAP_W(TW), .SETTLE_CYCLES(SC), .CHECK_CYCLES(CC)
   ) dut (
      .ACLK    (clk),
      .ARESETN (rst_n),
      .bus     (ifc)
   );

   // ---------------- lane pattern-checker model ----------------
   logic [31:0] mask0, mask1, sel_mask;
   logic        glitch;
   always_comb sel_mask = (ifc.lane_sel == 1'b1) ? mask1 : mask0;
   assign ifc.pattern_ok = sel_mask[ifc.tap_value] & ~glitch;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   logic [18:0] exp_q[$];   // {lane[7:0], tap[4:0], width[5:0]}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rng(input int lo, input int hi);
      logic [31:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic expect_lane(input int lane, input int tap, input int width);
      exp_q.push_back({8'(lane), 5'(tap), 6'(width)});
   endtask

   // Monitor: pops one expectation per lane result, counts done pulses.
   always @(negedge clk) begin
      logic [18:0] e;
      if (rst_n && ifc.result_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: lane %0d tap %0d width %0d, expected none",
                     ifc.lane_sel, ifc.result_tap, ifc.result_width);
         end else begin
            e = exp_q.pop_front();
            check("result_lane",  32'(ifc.lane_sel),     32'(e[18:11]));
            check("result_tap",   32'(ifc.result_tap),   32'(e[10:6]));
            check("result_width", 32'(ifc.result_width), 32'(e[5:0]));
            check("apply_load",   32'(ifc.tap_load),     32'd1);
            check("apply_value",  32'(ifc.tap_value),    32'(e[10:6]));
         end
      end
      if (rst_n && ifc.done) begin
         done_cnt++;
         check("busy_with_done", 32'(ifc.busy), 32'd1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      @(negedge clk);
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   task automatic run_scan(input string name, input logic [NL-1:0] exp_fail);
      int cyc;
      bit got_done;
      pulse_start();
      check({name, "_busy_first"},  32'(ifc.busy),      32'd1);
      check({name, "_load_first"},  32'(ifc.tap_load),  32'd1);
      check({name, "_tap_first"},   32'(ifc.tap_value), 32'd0);
      cyc = 1;
      got_done = 1'b0;
      while (cyc < 3 * SCAN_CYC && !got_done) begin
         if (ifc.done) got_done = 1'b1;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      check({name, "_done_seen"},  32'(got_done), 32'd1);
      check({name, "_done_cycle"}, 32'(cyc),      32'(SCAN_CYC));
      @(negedge clk);
      check({name, "_busy_after"}, 32'(ifc.busy),      32'd0);
      check({name, "_lane_fail"},  32'(ifc.lane_fail), 32'(exp_fail));
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_for(input int lane, input int tap, input logic [2:0] st, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * SCAN_CYC && !ok; i++) begin
         @(negedge clk);
         if (ifc.lane_sel == 1'(lane) && ifc.tap_value == 5'(tap) && ifc.dbg_state == st)
            ok = 1'b1;
      end
   endtask

   task automatic glitch_at(input int lane, input int tap);
      bit ok;
      wait_for(lane, tap, S_LOAD, ok);
      check("glitch_target_found", 32'(ok), 32'd1);
      if (ok) begin
         repeat (SC + 3) @(negedge clk);
         glitch = 1'b1;
         @(negedge clk);
         glitch = 1'b0;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit ok;
      int d0, loads;
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      mask0 = '0;
      mask1 = '0;
      glitch = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_busy",         32'(ifc.busy),         32'd0);
      check("rst_done",         32'(ifc.done),         32'd0);
      check("rst_lane_sel",     32'(ifc.lane_sel),     32'd0);
      check("rst_tap_load",     32'(ifc.tap_load),     32'd0);
      check("rst_tap_value",    32'(ifc.tap_value),    32'd0);
      check("rst_result_valid", 32'(ifc.result_valid), 32'd0);
      check("rst_result_tap",   32'(ifc.result_tap),   32'd0);
      check("rst_result_width", 32'(ifc.result_width), 32'd0);
      check("rst_lane_fail",    32'(ifc.lane_fail),    32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Full-open eye on both lanes.
      mask0 = '1; mask1 = '1;
      expect_lane(0, 15, 32);
      expect_lane(1, 15, 32);
      run_scan("all_pass", 2'b00);

      // Single eyes; a stray start mid-scan must not disturb timing.
      mask0 = rng(10, 20);
      mask1 = rng(2, 5) | rng(20, 27);
      expect_lane(0, 15, 11);
      expect_lane(1, 23, 8);
      fork
         run_scan("eye_mid", 2'b00);
         begin
            repeat (200) @(negedge clk);
            ifc.start = 1'b1;
            @(negedge clk);
            ifc.start = 1'b0;
         end
      join

      // Glitch splits lane 0's eye; lane 1 has two equal eyes.
      mask0 = rng(10, 20);
      mask1 = rng(0, 3) | rng(8, 11);
      expect_lane(0, 16, 8);
      expect_lane(1, 1, 4);
      fork
         run_scan("glitch_tie", 2'b00);
         glitch_at(0, 12);
      join

      // Lane 1 never passes.
      mask0 = '1; mask1 = '0;
      expect_lane(0, 15, 32);
      expect_lane(1, 0, 0);
      run_scan("lane1_fail", 2'b10);

      // start together with abort in IDLE is ignored.
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.abort = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      check("start_abort_busy",      32'(ifc.busy),      32'd0);
      check("start_abort_tap_load",  32'(ifc.tap_load),  32'd0);
      check("start_abort_lane_fail", 32'(ifc.lane_fail), 32'h2);

      // Abort during lane 1 CHECK: lane 0 result and fail bit survive.
      mask0 = '0; mask1 = '1;
      expect_lane(0, 0, 0);
      d0 = done_cnt;
      pulse_start();
      wait_for(1, 0, S_CHECK, ok);
      check("abort_target_found", 32'(ok), 32'd1);
      ifc.abort = 1'b1;
      @(negedge clk);
      ifc.abort = 1'b0;
      check("abort_busy",      32'(ifc.busy),      32'd0);
      check("abort_tap_load",  32'(ifc.tap_load),  32'd0);
      check("abort_lane_fail", 32'(ifc.lane_fail), 32'h1);
      loads = 0;
      repeat (SCAN_CYC) begin
         @(negedge clk);
         if (ifc.tap_load) loads++;
      end
      check("abort_no_done",     32'(done_cnt - d0),  32'd0);
      check("abort_no_tap_load", 32'(loads),          32'd0);
      check("abort_queue_empty", 32'(exp_q.size()),   32'd0);

      // Asynchronous reset in lane 1 SETTLE of tap 3.
      mask0 = '1; mask1 = '1;
      expect_lane(0, 15, 32);
      pulse_start();
      wait_for(1, 3, S_SETTLE, ok);
      check("reset_target_found", 32'(ok), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy",      32'(ifc.busy),      32'd0);
      check("arst_tap_load",  32'(ifc.tap_load),  32'd0);
      check("arst_lane_sel",  32'(ifc.lane_sel),  32'd0);
      check("arst_tap_value", 32'(ifc.tap_value), 32'd0);
      check("arst_state",     32'(ifc.dbg_state), 32'(S_IDLE));
      check("arst_queue",     32'(exp_q.size()),  32'd0);
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("arst_no_done", 32'(done_cnt - d0), 32'd0);

      mask0 = rng(10, 20);
      mask1 = '1;
      expect_lane(0, 15, 11);
      expect_lane(1, 15, 32);
      run_scan("after_reset", 2'b00);

      repeat (5) @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
